// File: rtl/serial_uart_bridge_pkg.sv
// rtl/serial_uart_bridge_pkg.sv - shared constants, FSM encodings and parity helper for the serial UART bridge
//
// Purpose : common definitions imported by serial_uart_bridge and serial_fifo.
//           DATA_W          - byte width carried on the serial port (8)
//           UART_IDLE_LEVEL - line level while no frame is in flight (1)
//           tx_state_t      - transmitter FSM states
//           rx_state_t      - receiver FSM states
//           even_parity()   - even-parity bit for one data byte
package serial_uart_bridge_pkg;

  localparam int   DATA_W          = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  // RX_BREAK holds off re-arming after a framing error until the line is back high,
  // so a long low (break) is not mistaken for a string of start bits.
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/serial_fifo.sv
// rtl/serial_fifo.sv - show-ahead synchronous FIFO used for the bridge TX and RX byte queues
//
// Purpose : DEPTH-entry (power of 2) FIFO, W bits wide, head visible without a pop.
// Ports   : clock  in  1      rising-edge clock
//           reset  in  1      asynchronous active-low reset, empties the FIFO
//           push   in  1      write wdata (ignored when full unless a pop happens in the same cycle)
//           wdata  in  W      data to write
//           pop    in  1      remove head (ignored when empty)
//           full   out 1      no free entry
//           empty  out 1      no valid entry
//           head   out W      oldest entry
module serial_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the index bits match.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         wr_en;
  logic         rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push && (!full || rd_en);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/serial_uart_bridge.sv
// rtl/serial_uart_bridge.sv - core serial port to UART TX/RX bridge with byte FIFOs and sticky error flags
//
// Purpose : bytes written by the core are queued and sent 8N1 (LSB first) on uart_tx_out;
//           frames on uart_rx_in are deserialised into a show-ahead queue the core reads.
// Option  : SERIAL_BRIDGE_PARITY_EN defined -> 8E1 framing, even parity after D7 on both
//           directions, RX mismatch drops the byte and sets rx_parity_err_out.
//           Undefined -> 8N1, rx_parity_err_out tied 0.
// Ports   : clock             in  1  rising-edge clock
//           reset             in  1  asynchronous active-low reset
//           core_wdata_in     in  8  byte from core
//           core_wren_in      in  1  core write strobe
//           core_rden_in      in  1  core consume strobe
//           core_rdata_out    out 8  RX queue head (0 when empty)
//           core_valid_out    out 1  RX queue non-empty
//           core_ready_out    out 1  TX queue not full
//           uart_rx_in        in  1  asynchronous line input, idle high
//           uart_tx_out       out 1  registered line output, idle high
//           tx_overflow_out   out 1  sticky: write while TX queue full
//           rx_overrun_out    out 1  sticky: byte received while RX queue full
//           rx_frame_err_out  out 1  sticky: stop bit sampled low
//           rx_parity_err_out out 1  sticky: parity mismatch
module serial_uart_bridge
  import serial_uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TX_DEPTH     = 8,
  parameter int RX_DEPTH     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] core_wdata_in,
  input  logic              core_wren_in,
  input  logic              core_rden_in,
  output logic [DATA_W-1:0] core_rdata_out,
  output logic              core_valid_out,
  output logic              core_ready_out,
  input  logic              uart_rx_in,
  output logic              uart_tx_out,
  output logic              tx_overflow_out,
  output logic              rx_overrun_out,
  output logic              rx_frame_err_out,
  output logic              rx_parity_err_out
);

  localparam int          BW       = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BIT_END  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_END = BW'(CLKS_PER_BIT / 2 - 1);

  // ---------------------------------------------------------------- TX queue
  logic              tx_full;
  logic              tx_empty;
  logic [DATA_W-1:0] tx_head;
  logic              tx_pop;
  logic              tx_push;

  assign tx_push = core_wren_in && !tx_full;

  serial_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (tx_push),
    .wdata (core_wdata_in),
    .pop   (tx_pop),
    .full  (tx_full),
    .empty (tx_empty),
    .head  (tx_head)
  );

  // ---------------------------------------------------------------- TX FSM
  tx_state_t         tx_state,  tx_state_n;
  logic [BW-1:0]     tx_baud,   tx_baud_n;
  logic [2:0]        tx_bit,    tx_bit_n;
  logic [DATA_W-1:0] tx_shift,  tx_shift_n;
  logic              tx_line,   tx_line_n;
  logic              tx_load;
`ifdef SERIAL_BRIDGE_PARITY_EN
  logic              tx_par,    tx_par_n;
`endif

  always_comb begin
    tx_state_n = tx_state;
    tx_baud_n  = tx_baud;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_line_n  = tx_line;
    tx_load    = 1'b0;
    tx_pop     = 1'b0;
`ifdef SERIAL_BRIDGE_PARITY_EN
    tx_par_n   = tx_par;
`endif
    case (tx_state)
      TX_IDLE: begin
        tx_line_n = UART_IDLE_LEVEL;
        tx_load   = !tx_empty;
      end
      TX_START: begin
        if (tx_baud == BIT_END) begin
          tx_baud_n  = '0;
          tx_bit_n   = '0;
          tx_line_n  = tx_shift[0];
          tx_state_n = TX_DATA;
        end else begin
          tx_baud_n = tx_baud + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_baud == BIT_END) begin
          tx_baud_n = '0;
          if (tx_bit == 3'd7) begin
`ifdef SERIAL_BRIDGE_PARITY_EN
            tx_line_n  = tx_par;
            tx_state_n = TX_PARITY;
`else
            tx_line_n  = UART_IDLE_LEVEL;
            tx_state_n = TX_STOP;
`endif
          end else begin
            tx_bit_n   = tx_bit + 3'd1;
            tx_shift_n = tx_shift >> 1;
            tx_line_n  = tx_shift[1];
          end
        end else begin
          tx_baud_n = tx_baud + 1'b1;
        end
      end
`ifdef SERIAL_BRIDGE_PARITY_EN
      TX_PARITY: begin
        if (tx_baud == BIT_END) begin
          tx_baud_n  = '0;
          tx_line_n  = UART_IDLE_LEVEL;
          tx_state_n = TX_STOP;
        end else begin
          tx_baud_n = tx_baud + 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (tx_baud == BIT_END) begin
          // Chain straight into the next start bit when more data is queued.
          tx_baud_n  = '0;
          tx_line_n  = UART_IDLE_LEVEL;
          tx_state_n = TX_IDLE;
          tx_load    = !tx_empty;
        end else begin
          tx_baud_n = tx_baud + 1'b1;
        end
      end
      default: begin
        tx_line_n  = UART_IDLE_LEVEL;
        tx_state_n = TX_IDLE;
      end
    endcase

    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_shift_n = tx_head;
      tx_baud_n  = '0;
      tx_line_n  = 1'b0;
      tx_state_n = TX_START;
`ifdef SERIAL_BRIDGE_PARITY_EN
      tx_par_n   = even_parity(tx_head);
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= UART_IDLE_LEVEL;
`ifdef SERIAL_BRIDGE_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      tx_baud  <= tx_baud_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
`ifdef SERIAL_BRIDGE_PARITY_EN
      tx_par   <= tx_par_n;
`endif
    end
  end

  assign uart_tx_out = tx_line;

  // ---------------------------------------------------------------- RX synchroniser
  logic [1:0] rx_sync;
  logic       rx_s;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rx_sync <= {2{UART_IDLE_LEVEL}};
    else        rx_sync <= {rx_sync[0], uart_rx_in};
  end

  assign rx_s = rx_sync[1];

  // ---------------------------------------------------------------- RX FSM
  rx_state_t         rx_state,  rx_state_n;
  logic [BW-1:0]     rx_baud,   rx_baud_n;
  logic [2:0]        rx_bit,    rx_bit_n;
  logic [DATA_W-1:0] rx_shift,  rx_shift_n;
  logic              rx_push_req;
  logic              rx_frame_set;
  logic              rx_parity_set;
`ifdef SERIAL_BRIDGE_PARITY_EN
  logic              rx_par,    rx_par_n;
`endif

  always_comb begin
    rx_state_n    = rx_state;
    rx_baud_n     = rx_baud;
    rx_bit_n      = rx_bit;
    rx_shift_n    = rx_shift;
    rx_push_req   = 1'b0;
    rx_frame_set  = 1'b0;
    rx_parity_set = 1'b0;
`ifdef SERIAL_BRIDGE_PARITY_EN
    rx_par_n      = rx_par;
`endif
    case (rx_state)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_baud_n  = '0;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        // Re-check at half a bit: a low that has already gone away was noise.
        if (rx_baud == HALF_END) begin
          rx_baud_n  = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_baud_n = rx_baud + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_baud == BIT_END) begin
          rx_baud_n  = '0;
          rx_shift_n = {rx_s, rx_shift[DATA_W-1:1]};
          if (rx_bit == 3'd7) begin
`ifdef SERIAL_BRIDGE_PARITY_EN
            rx_state_n = RX_PARITY;
`else
            rx_state_n = RX_STOP;
`endif
          end else begin
            rx_bit_n = rx_bit + 3'd1;
          end
        end else begin
          rx_baud_n = rx_baud + 1'b1;
        end
      end
`ifdef SERIAL_BRIDGE_PARITY_EN
      RX_PARITY: begin
        if (rx_baud == BIT_END) begin
          rx_baud_n  = '0;
          rx_par_n   = rx_s;
          rx_state_n = RX_STOP;
        end else begin
          rx_baud_n = rx_baud + 1'b1;
        end
      end
`endif
      RX_STOP: begin
        if (rx_baud == BIT_END) begin
          rx_baud_n = '0;
          if (rx_s) begin
            rx_state_n = RX_IDLE;
`ifdef SERIAL_BRIDGE_PARITY_EN
            if (even_parity(rx_shift) != rx_par) rx_parity_set = 1'b1;
            else                                 rx_push_req   = 1'b1;
`else
            rx_push_req = 1'b1;
`endif
          end else begin
            rx_frame_set = 1'b1;
            rx_state_n   = RX_BREAK;
          end
        end else begin
          rx_baud_n = rx_baud + 1'b1;
        end
      end
      RX_BREAK: begin
        if (rx_s) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
`ifdef SERIAL_BRIDGE_PARITY_EN
      rx_par   <= 1'b0;
`endif
    end else begin
      rx_state <= rx_state_n;
      rx_baud  <= rx_baud_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
`ifdef SERIAL_BRIDGE_PARITY_EN
      rx_par   <= rx_par_n;
`endif
    end
  end

  // ---------------------------------------------------------------- RX queue
  logic              rx_full;
  logic              rx_empty;
  logic [DATA_W-1:0] rx_head;
  logic              rx_pop;

  assign rx_pop = core_rden_in && !rx_empty;

  serial_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx_push_req),
    .wdata (rx_shift),
    .pop   (rx_pop),
    .full  (rx_full),
    .empty (rx_empty),
    .head  (rx_head)
  );

  assign core_valid_out = !rx_empty;
  assign core_rdata_out = rx_empty ? '0 : rx_head;
  assign core_ready_out = !tx_full;

  // ---------------------------------------------------------------- sticky flags
  logic rx_parity_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_overflow_out  <= 1'b0;
      rx_overrun_out   <= 1'b0;
      rx_frame_err_out <= 1'b0;
      rx_parity_err    <= 1'b0;
    end else begin
      if (core_wren_in && tx_full)            tx_overflow_out  <= 1'b1;
      if (rx_push_req && rx_full && !rx_pop)  rx_overrun_out   <= 1'b1;
      if (rx_frame_set)                       rx_frame_err_out <= 1'b1;
      if (rx_parity_set)                      rx_parity_err    <= 1'b1;
    end
  end

`ifdef SERIAL_BRIDGE_PARITY_EN
  assign rx_parity_err_out = rx_parity_err;
`else
  assign rx_parity_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_serial_uart_bridge.sv
// tb/tb_serial_uart_bridge.sv - self-checking bench for serial_uart_bridge (CLKS_PER_BIT=4, TX_DEPTH=8, RX_DEPTH=4)
`timescale 1ns/1ps
module tb_serial_uart_bridge;

  localparam int CPB = 4;
`ifdef SERIAL_BRIDGE_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] core_wdata_in = 8'h00;
  logic       core_wren_in = 1'b0;
  logic       core_rden_in = 1'b0;
  logic [7:0] core_rdata_out;
  logic       core_valid_out;
  logic       core_ready_out;
  logic       uart_rx_in = 1'b1;
  logic       uart_tx_out;
  logic       tx_overflow_out;
  logic       rx_overrun_out;
  logic       rx_frame_err_out;
  logic       rx_parity_err_out;

  int errors = 0;
  int checks = 0;

  serial_uart_bridge #(.CLKS_PER_BIT(CPB), .TX_DEPTH(8), .RX_DEPTH(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .core_wdata_in     (core_wdata_in),
    .core_wren_in      (core_wren_in),
    .core_rden_in      (core_rden_in),
    .core_rdata_out    (core_rdata_out),
    .core_valid_out    (core_valid_out),
    .core_ready_out    (core_ready_out),
    .uart_rx_in        (uart_rx_in),
    .uart_tx_out       (uart_tx_out),
    .tx_overflow_out   (tx_overflow_out),
    .rx_overrun_out    (rx_overrun_out),
    .rx_frame_err_out  (rx_frame_err_out),
    .rx_parity_err_out (rx_parity_err_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       rden;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } rx_vec_t;

  rx_vec_t    rx_tab [6];
  logic [7:0] tx_tab [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic tx_write(input logic [7:0] b);
    core_wdata_in = b;
    core_wren_in  = 1'b1;
    @(negedge clock);
    core_wren_in  = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then compares every cycle of the frame against
  // the expected line pattern. Returns with the first sample after the stop bit current.
  task automatic tx_capture(input logic [7:0] b, input string name, output int gap);
    logic [FRAME_BITS-1:0] pat;
    int bad;
`ifdef SERIAL_BRIDGE_PARITY_EN
    pat = {1'b1, ^b, b, 1'b0};
`else
    pat = {1'b1, b, 1'b0};
`endif
    gap = 0;
    while (uart_tx_out !== 1'b0 && gap < 200) begin
      @(negedge clock);
      gap++;
    end
    check($sformatf("%s start seen", name), uart_tx_out, 1'b0);
    bad = 0;
    for (int i = 0; i < FRAME_BITS; i++) begin
      for (int c = 0; c < CPB; c++) begin
        if (uart_tx_out !== pat[i]) bad++;
        @(negedge clock);
      end
    end
    check($sformatf("%s waveform bad samples", name), bad, 0);
  endtask

  function automatic logic [10:0] rx_frame(input logic [7:0] b, input logic stop);
`ifdef SERIAL_BRIDGE_PARITY_EN
    return {stop, ^b, b, 1'b0};
`else
    return {1'b0, stop, b, 1'b0};
`endif
  endfunction

  task automatic rx_send_bits(input logic [10:0] bits);
    for (int i = 0; i < FRAME_BITS; i++) begin
      uart_rx_in = bits[i];
      repeat (CPB) @(negedge clock);
    end
    uart_rx_in = 1'b1;
    repeat (2 * CPB) @(negedge clock);
  endtask

  initial begin
    int lat;
    int gap;
    int lows;

    rx_tab[0] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0};
    rx_tab[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
    rx_tab[2] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0};
    rx_tab[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0};
    rx_tab[4] = '{8'h81, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    rx_tab[5] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1};
    tx_tab[0] = 8'h00;
    tx_tab[1] = 8'hFF;
    tx_tab[2] = 8'h0F;
    tx_tab[3] = 8'hA5;

    // Reset state
    repeat (3) @(negedge clock);
    check("reset tx line", uart_tx_out, 1'b1);
    check("reset ready", core_ready_out, 1'b1);
    check("reset valid", core_valid_out, 1'b0);
    check("reset rdata", core_rdata_out, 8'h00);
    check("reset flags", {tx_overflow_out, rx_overrun_out, rx_frame_err_out, rx_parity_err_out}, 4'h0);
    reset = 1'b1;
    @(negedge clock);

    // 0x55: start bit within 2 cycles of the write edge, exact frame, then idle
    tx_write(8'h55);
    lat = 1;
    while (uart_tx_out !== 1'b0 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("tx 0x55 start latency <= 2", lat <= 2, 1'b1);
    tx_capture(8'h55, "tx 0x55", gap);
    lows = 0;
    repeat (8) begin
      if (uart_tx_out !== 1'b1) lows++;
      @(negedge clock);
    end
    check("tx idle after 0x55", lows, 0);

    // TX table
    foreach (tx_tab[k]) begin
      tx_write(tx_tab[k]);
      tx_capture(tx_tab[k], $sformatf("tx tab %0d", k), gap);
    end

    // Reset in the middle of a 0xA5 frame
    tx_write(8'hA5);
    repeat (10) @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid-frame reset tx line", uart_tx_out, 1'b1);
    check("mid-frame reset ready", core_ready_out, 1'b1);
    check("mid-frame reset flags", {tx_overflow_out, rx_overrun_out, rx_frame_err_out, rx_parity_err_out}, 4'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    lows = 0;
    repeat (60) begin
      @(negedge clock);
      if (uart_tx_out !== 1'b1) lows++;
    end
    check("no frame after mid-frame reset", lows, 0);

    // RX table
    foreach (rx_tab[k]) begin
      rx_send_bits(rx_frame(rx_tab[k].b, rx_tab[k].stop));
      check($sformatf("rx tab %0d valid", k), core_valid_out, rx_tab[k].exp_valid);
      check($sformatf("rx tab %0d rdata", k), core_rdata_out, rx_tab[k].exp_data);
      check($sformatf("rx tab %0d frame_err", k), rx_frame_err_out, rx_tab[k].exp_ferr);
      if (rx_tab[k].rden) begin
        core_rden_in = 1'b1;
        @(negedge clock);
        core_rden_in = 1'b0;
        check($sformatf("rx tab %0d valid after rden", k), core_valid_out, 1'b0);
      end
    end

    // Glitch on the RX line is a false start, and the receiver re-arms afterwards
    do_reset();
    uart_rx_in = 1'b0;
    repeat (2) @(negedge clock);
    uart_rx_in = 1'b1;
    repeat (20) @(negedge clock);
    check("glitch no byte", core_valid_out, 1'b0);
    check("glitch no frame_err", rx_frame_err_out, 1'b0);
    rx_send_bits(rx_frame(8'h96, 1'b1));
    check("after glitch rdata", core_rdata_out, 8'h96);

    // RX overrun: 5 frames into a 4-deep queue
    do_reset();
    for (int k = 0; k < 5; k++) begin
      rx_send_bits(rx_frame(8'(8'h11 * (k + 1)), 1'b1));
      if (k == 3) check("overrun clear after 4", rx_overrun_out, 1'b0);
    end
    check("overrun set after 5", rx_overrun_out, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("overrun order %0d", k), core_rdata_out, 8'(8'h11 * (k + 1)));
      core_rden_in = 1'b1;
      @(negedge clock);
      core_rden_in = 1'b0;
    end
    check("overrun drained valid", core_valid_out, 1'b0);
    core_rden_in = 1'b1;
    @(negedge clock);
    core_rden_in = 1'b0;
    check("rden while empty ignored", core_valid_out, 1'b0);

    // TX overflow: 10 back-to-back writes; the first byte moves straight into the
    // shifter, so 9 are accepted (0x10..0x18) and 0x19 is dropped.
    do_reset();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          core_wdata_in = 8'(8'h10 + i);
          core_wren_in  = 1'b1;
          @(negedge clock);
        end
        core_wren_in = 1'b0;
        check("overflow ready low", core_ready_out, 1'b0);
        check("overflow flag", tx_overflow_out, 1'b1);
      end
      begin
        int g;
        for (int k = 0; k < 9; k++) begin
          tx_capture(8'(8'h10 + k), $sformatf("b2b frame %0d", k), g);
          if (k > 0) check($sformatf("b2b gap before frame %0d", k), g, 0);
        end
      end
    join
    repeat (4 * CPB) @(negedge clock);
    check("after b2b line idle", uart_tx_out, 1'b1);
    check("after b2b ready", core_ready_out, 1'b1);

`ifdef SERIAL_BRIDGE_PARITY_EN
    // 0x07 has three ones, so its even parity bit is 1; send 0 instead
    do_reset();
    rx_send_bits({1'b1, 1'b0, 8'h07, 1'b0});
    check("parity err set", rx_parity_err_out, 1'b1);
    check("parity err no byte", core_valid_out, 1'b0);
`else
    check("parity err tied low", rx_parity_err_out, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
